// File: rtl/otter_arb_pkg.sv
// Shared types and default widths for the OTTER unified-memory arbiter.
package otter_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_CNT_W  = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Fetch, data and memory-side bus bundle for otter_mem_arbiter.
// slave = arbiter side; master = requesters plus memory model.
interface otter_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/otter_arb_starve_ctr.sv
// Counts DM grants won while IF was waiting; raises force_if_c at the limit.
module otter_arb_starve_ctr
    import otter_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic dm_gnt,
    output logic force_if_c
);

    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

    // Only DM wins that actually blocked IF count toward starvation.
    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt) begin
            cnt_d = '0;
        end else if (dm_gnt) begin
            if (!if_req) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + ARB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign force_if_c = (cnt_q == ARB_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/otter_mem_arbiter.sv
// Single-outstanding arbiter sharing OTTER unified memory between IF and DM.
// Optional IF anti-starvation enabled by defining ARB_FAIRNESS_EN.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ARB_ADDR_W,
    parameter int unsigned DATA_W       = ARB_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    otter_mem_arbiter_if.slave  bus
);

    localparam int unsigned BE_W = DATA_W / 8;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("otter_mem_arbiter: STARVE_LIMIT must be 1..15");
    end

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_gnt_c, dm_gnt_c, force_if_c;

`ifdef ARB_FAIRNESS_EN
    otter_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (bus.if_req),
        .if_gnt     (if_gnt_c),
        .dm_gnt     (dm_gnt_c),
        .force_if_c (force_if_c)
    );
`else
    assign force_if_c = 1'b0;
`endif

    // Next-state, grant and response logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_gnt_c    = 1'b0;
        dm_gnt_c    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.dm_req && !(bus.if_req && force_if_c)) begin
                    dm_gnt_c    = 1'b1;
                    owner_d     = OWN_DM;
                    state_d     = ARB_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_be_d    = bus.dm_be;
                end else if (bus.if_req) begin
                    if_gnt_c    = 1'b1;
                    owner_d     = OWN_IF;
                    state_d     = ARB_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                end
            end
            ARB_BUSY: begin
                if (bus.mem_ack) begin
                    state_d   = ARB_IDLE;
                    owner_d   = OWN_NONE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end else if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.dm_gnt    = dm_gnt_c;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter; grant-order expectations follow ARB_FAIRNESS_EN.
module tb_otter_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    otter_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    otter_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, wanted $finish");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 after the edge; checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0;
        bus.dm_wdata = '0; bus.dm_be = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick(); tick();
        #1;
        n_cmp++;
        if ({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_req, bus.mem_we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_req, bus.mem_we});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.dm_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wdata=%h be=%h ird=%h drd=%h want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.dm_rdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_if_fetch();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1;
        n_cmp++;
        if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL if_grant: got if_gnt=%b dm_gnt=%b mem_req=%b want 1 0 0",
                     bus.if_gnt, bus.dm_gnt, bus.mem_req);
        end
        tick();
        bus.if_req = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
            n_err++;
            $display("FAIL if_qual: got req=%b addr=%h we=%b be=%h want 1 100 0 f",
                     bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be);
        end
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL if_early_rvalid: got %b want 0", bus.if_rvalid);
        end
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h13 || bus.dm_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL if_resp: got rvalid=%b rdata=%h dm_rvalid=%b mem_req=%b want 1 13 0 0",
                     bus.if_rvalid, bus.if_rdata, bus.dm_rvalid, bus.mem_req);
        end
        tick();
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h13) begin
            n_err++;
            $display("FAIL if_hold: got rvalid=%b rdata=%h want 0 13", bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_dm_priority();
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2000;
        bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'h3;
        #1;
        n_cmp++;
        if (bus.dm_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL prio_grant: got dm_gnt=%b if_gnt=%b want 1 0", bus.dm_gnt, bus.if_gnt);
        end
        tick();
        bus.dm_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555;
        #1;
        n_cmp++;
        if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'h3 || bus.mem_addr !== 32'h2000 ||
            bus.mem_wdata !== 32'hDEAD_BEEF || bus.if_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL store_qual: got we=%b be=%h addr=%h wdata=%h if_gnt=%b want 1 3 2000 deadbeef 0",
                     bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.if_gnt);
        end
        tick();
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'h0 || bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL store_resp: got rvalid=%b rdata=%h if_gnt=%b dm_gnt=%b want 1 0 1 0",
                     bus.dm_rvalid, bus.dm_rdata, bus.if_gnt, bus.dm_gnt);
        end
        tick();
        bus.if_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0040_0093;
        #1;
        n_cmp++;
        if (bus.mem_addr !== 32'h104 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
            n_err++;
            $display("FAIL if_after_dm_qual: got addr=%h we=%b be=%h want 104 0 f",
                     bus.mem_addr, bus.mem_we, bus.mem_be);
        end
        tick();
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0040_0093 || bus.dm_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL if_after_dm_resp: got rvalid=%b rdata=%h dm_rvalid=%b want 1 00400093 0",
                     bus.if_rvalid, bus.if_rdata, bus.dm_rvalid);
        end
        tick();
    endtask

    task automatic test_ack_delay();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h3000;
        bus.dm_wdata = 32'h1234_5678; bus.dm_be = 4'hF;
        #1;
        n_cmp++;
        if (bus.dm_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL delay_grant: got %b want 1", bus.dm_gnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.dm_addr = 32'h3000 + 32'(4 * (i + 1));
            #1;
            n_cmp++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h3000 || bus.mem_we !== 1'b0 ||
                bus.mem_be !== 4'hF || bus.dm_gnt !== 1'b0 || bus.if_gnt !== 1'b0 || bus.dm_rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL delay_hold[%0d]: got req=%b addr=%h we=%b be=%h gnt=%b%b rv=%b want 1 3000 0 f 00 0",
                         i, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be, bus.dm_gnt, bus.if_gnt, bus.dm_rvalid);
            end
        end
        tick();
        bus.dm_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hCAFE_F00D || bus.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL delay_resp: got rvalid=%b rdata=%h mem_req=%b want 1 cafef00d 0",
                     bus.dm_rvalid, bus.dm_rdata, bus.mem_req);
        end
        tick();
    endtask

    task automatic test_spurious_ack();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0 || bus.mem_req !== 1'b0 ||
            bus.dm_rdata !== 32'hCAFE_F00D || bus.if_rdata !== 32'h0040_0093) begin
            n_err++;
            $display("FAIL spurious_ack: got irv=%b drv=%b req=%b drd=%h ird=%h want 0 0 0 cafef00d 00400093",
                     bus.if_rvalid, bus.dm_rvalid, bus.mem_req, bus.dm_rdata, bus.if_rdata);
        end
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h108;
        #1;
        n_cmp++;
        if (bus.if_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL spurious_still_idle: got if_gnt=%b want 1", bus.if_gnt);
        end
        tick();
        bus.if_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0073;
        tick();
        bus.mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        tick();
        bus.if_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_req !== 1'b0 || bus.if_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got mem_req=%b if_rdata=%h want 0 0", bus.mem_req, bus.if_rdata);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got irv=%b drv=%b req=%b want 0 0 0",
                     bus.if_rvalid, bus.dm_rvalid, bus.mem_req);
        end
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        #1;
        n_cmp++;
        if (bus.if_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_grant: got %b want 1", bus.if_gnt);
        end
        tick();
        bus.if_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00A0_0093;
        #1;
        n_cmp++;
        if (bus.mem_addr !== 32'h300 || bus.mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_qual: got addr=%h req=%b want 300 1", bus.mem_addr, bus.mem_req);
        end
        tick();
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00A0_0093) begin
            n_err++;
            $display("FAIL post_reset_resp: got rvalid=%b rdata=%h want 1 00a00093", bus.if_rvalid, bus.if_rdata);
        end
        tick();
    endtask

    task automatic test_fairness();
        bit want_if;
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h4000; bus.dm_be = 4'hF;
        for (int k = 0; k < 10; k++) begin
            #1;
`ifdef ARB_FAIRNESS_EN
            want_if = ((k % 5) == 4);
`else
            want_if = 1'b0;
`endif
            n_cmp++;
            if (bus.if_gnt !== want_if || bus.dm_gnt !== !want_if) begin
                n_err++;
                $display("FAIL fair_order[%0d]: got if_gnt=%b dm_gnt=%b want %b %b",
                         k, bus.if_gnt, bus.dm_gnt, want_if, !want_if);
            end
            tick();
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'(k);
            if (k == 9) begin
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
            end
            tick();
            bus.mem_ack = 1'b0;
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_if_fetch();
        test_dm_priority();
        test_ack_delay();
        test_spurious_ack();
        test_reset_mid_busy();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Arbiter that shares the OTTER's single-port unified memory between the instruction-fetch requester (IF) and the data-memory requester (DM, loads and stores). It sits between the pipeline's fetch and memory stages and the memory wrapper. It accepts at most one outstanding transaction and grants DM ahead of IF by default. An optional anti-starvation counter guarantees IF forward progress.

## Interface
- ADDR_W, 32: address width
- DATA_W, 32: data width; byte enables are DATA_W/8 wide
- STARVE_LIMIT, 4: consecutive contended DM grants before IF is forced (fairness build only); legal range 1–15
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- IF_REQ  in  1  fetch request; held with IF_ADDR stable until IF_GNT
- IF_ADDR  in  ADDR_W  fetch address
- IF_GNT  out  1  fetch request accepted this cycle
- IF_RVALID  out  1  one-cycle pulse; IF_RDATA valid
- IF_RDATA  out  DATA_W  fetched word
- DM_REQ  in  1  data request; held with its qualifiers stable until DM_GNT
- DM_WE  in  1  1 = store, 0 = load
- DM_ADDR  in  ADDR_W  data address
- DM_WDATA  in  DATA_W  store data
- DM_BE  in  DATA_W/8  byte enables
- DM_GNT  out  1  data request accepted this cycle
- DM_RVALID  out  1  one-cycle completion pulse for loads and stores
- DM_RDATA  out  DATA_W  load data; 0 on stores
- MEM_REQ  out  1  memory access in progress
- MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE  out  1/ADDR_W/DATA_W/DATA_W/8  latched access qualifiers
- MEM_ACK  in  1  one-cycle pulse; memory completed the access
- MEM_RDATA  in  DATA_W  read data, valid with MEM_ACK

## Operation
- States: ARB_IDLE, ARB_BUSY. Owner register: OWN_NONE, OWN_IF, OWN_DM.
- ARB_IDLE with any request present:
  - Grant one requester combinationally (GNT high the same cycle).
  - Latch the winner's qualifiers and owner. IF grants latch WE=0 and BE all-ones.
  - Go to ARB_BUSY.
- Priority: DM over IF when both request. A fairness override applies in the fairness build.
- ARB_BUSY:
  - MEM_REQ=1 with latched qualifiers held constant.
  - No GNT is issued.
  - Wait for MEM_ACK.
- On MEM_ACK in ARB_BUSY:
  - Register MEM_RDATA into the owner's RDATA (DM_RDATA=0 for stores).
  - Pulse the owner's RVALID the next cycle.
  - Return to ARB_IDLE, owner = OWN_NONE.
- MEM_ACK in ARB_IDLE is ignored: no RVALID, no state change.
- RDATA outputs hold their last value until the next response.

## Timing
- Reset values (async, RST_N low): state ARB_IDLE, owner OWN_NONE. All GNT, RVALID and MEM_* outputs are 0. RDATA is 0. Starve counter is 0.
- Reset asserted mid-transaction abandons it immediately: MEM_REQ drops without waiting for RST_N to rise, and no RVALID is produced.
- Latency: GNT at cycle T; MEM_REQ from T+1; MEM_ACK earliest T+1; RVALID at ACK+1.
- The RVALID cycle is an ARB_IDLE cycle, so a new GNT may coincide with it. Minimum 2 cycles per transaction.
- GNT is never asserted in ARB_BUSY. IF_GNT and DM_GNT are never both high.
- A request dropped before grant is legal and is simply not served.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A 4-bit counter increments on each DM grant made while IF_REQ is also high.
  - It clears on any IF grant, and on a DM grant made while IF_REQ is low.
  - When the counter equals STARVE_LIMIT and both requests are present, IF wins.
- Undefined: strict DM priority. IF can starve indefinitely under continuous DM traffic.

## Structure
- Package otter_arb_pkg: state_t {ARB_IDLE, ARB_BUSY}, owner_t {OWN_NONE, OWN_IF, OWN_DM}.
- Sub-module otter_arb_starve_ctr (counter plus force_if output), instantiated only under ARB_FAIRNESS_EN.

## Test plan
- IF only, IF_ADDR=0x100, ACK 1 cycle after MEM_REQ with MEM_RDATA=0x00000013 -> IF_GNT at T, MEM_ADDR=0x100, MEM_WE=0, MEM_BE=0xF, IF_RVALID with IF_RDATA=0x13 at T+3.
- IF and DM both request same cycle, DM store to 0x2000, BE=0x3 -> DM_GNT first, MEM_WE=1, MEM_BE=0x3. DM_RVALID with DM_RDATA=0. IF_GNT in the same cycle as DM_RVALID.
- ACK delayed 5 cycles -> MEM_* qualifiers stable for all 5 cycles, no GNT while DM_REQ is reasserted.
- Spurious MEM_ACK in ARB_IDLE -> no RVALID, state unchanged.
- RST_N pulled low 2 cycles into ARB_BUSY -> MEM_REQ=0 without waiting for RST_N to rise, no RVALID after release, fresh IF request served normally.
- ARB_FAIRNESS_EN, STARVE_LIMIT=4, both requesting continuously -> grant order DM,DM,DM,DM,IF, repeating. Without the macro -> DM only.
